// File: rtl/sec_set_ctrl_if.sv
// Button-side inputs and digit-register/display outputs of the seconds setting controller.
// The controller takes the slave view; the button/display side takes the master view.
interface sec_set_ctrl_if;
   logic       mode;
   logic       up;
   logic [3:0] cur_t;
   logic [3:0] cur_u;
   logic       set_t;
   logic       set_u;
   logic [3:0] new_val;
   logic       run_en;
   logic [3:0] disp_t;
   logic [3:0] disp_u;
   logic       blank_t;
   logic       blank_u;

   modport master (
      output mode, up, cur_t, cur_u,
      input  set_t, set_u, new_val, run_en, disp_t, disp_u, blank_t, blank_u
   );

   modport slave (
      input  mode, up, cur_t, cur_u,
      output set_t, set_u, new_val, run_en, disp_t, disp_u, blank_t, blank_u
   );
endinterface

// File: rtl/sec_set_ctrl.sv
// Seconds-digit setting controller: edit session on shadow tens/units digits, with blink,
// auto-repeat, an inactivity timeout and a two-strobe commit to the digit registers.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | normal counting, display follows the digit registers
// EDIT_T   | editing shadow tens digit (0..5), tens digit blinks
// EDIT_U   | editing shadow units digit (0..9), units digit blinks
// COMMIT_T | one-cycle load strobe of the shadow tens digit
// COMMIT_U | one-cycle load strobe of the shadow units digit
module sec_set_ctrl #(
   parameter int BLINK_HALF = 16,
   parameter int RPT_DELAY  = 8,
   parameter int RPT_PERIOD = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic          clk,
   input  logic          resetn,
   sec_set_ctrl_if.slave bus
);

   localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int RPT_W   = (RPT_MAX > 1)    ? $clog2(RPT_MAX)    : 1;
   localparam int TMO_W   = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;

   localparam logic [BLINK_W-1:0] BLINK_LD  = BLINK_W'(BLINK_HALF - 1);
   localparam logic [RPT_W-1:0]   RPT_LD_DL = RPT_W'(RPT_DELAY - 1);
   localparam logic [RPT_W-1:0]   RPT_LD_PR = RPT_W'(RPT_PERIOD - 1);
   localparam logic [TMO_W-1:0]   TMO_LD    = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EDIT_T   = 3'd1,
      EDIT_U   = 3'd2,
      COMMIT_T = 3'd3,
      COMMIT_U = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [3:0]         sh_t_q, sh_t_d;
   logic [3:0]         sh_u_q, sh_u_d;
   logic               up_q;
   logic               armed_q, armed_d;
   logic [RPT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               phase_q, phase_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

   logic in_edit;
   logic rise;
   logic rpt_tc;
   logic inc_evt;
   logic enter_edit;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         sh_t_q      <= '0;
         sh_u_q      <= '0;
         up_q        <= 1'b0;
         armed_q     <= 1'b0;
         rpt_cnt_q   <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         sh_t_q      <= sh_t_d;
         sh_u_q      <= sh_u_d;
         up_q        <= bus.up;
         armed_q     <= armed_d;
         rpt_cnt_q   <= rpt_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sh_t_d      = sh_t_q;
      sh_u_d      = sh_u_q;
      armed_d     = armed_q;
      rpt_cnt_d   = rpt_cnt_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      tmo_cnt_d   = tmo_cnt_q;

      in_edit = (state_q == EDIT_T) || (state_q == EDIT_U);
      rise    = bus.up & ~up_q;
      rpt_tc  = armed_q & bus.up & (rpt_cnt_q == '0);
      inc_evt = in_edit & ~bus.mode & (rise | rpt_tc);

      // Repeat only arms on an edge seen while editing, so a held button never carries over
      if (!bus.up || !in_edit) begin
         armed_d   = 1'b0;
         rpt_cnt_d = '0;
      end else if (rise) begin
         armed_d   = 1'b1;
         rpt_cnt_d = RPT_LD_DL;
      end else if (armed_q) begin
         rpt_cnt_d = (rpt_cnt_q == '0) ? RPT_LD_PR : rpt_cnt_q - 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.mode) begin
               state_d = EDIT_T;
               sh_t_d  = (bus.cur_t > 4'd5) ? 4'd0 : bus.cur_t;
               sh_u_d  = (bus.cur_u > 4'd9) ? 4'd0 : bus.cur_u;
            end
         end
         EDIT_T: begin
            if (bus.mode)                state_d = EDIT_U;
            else if (inc_evt)            sh_t_d  = (sh_t_q == 4'd5) ? 4'd0 : sh_t_q + 4'd1;
            else if (tmo_cnt_q == '0)    state_d = IDLE;
         end
         EDIT_U: begin
            if (bus.mode)                state_d = COMMIT_T;
            else if (inc_evt)            sh_u_d  = (sh_u_q == 4'd9) ? 4'd0 : sh_u_q + 4'd1;
            else if (tmo_cnt_q == '0)    state_d = IDLE;
         end
         COMMIT_T: state_d = COMMIT_U;
         COMMIT_U: state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      enter_edit = ((state_d == EDIT_T) || (state_d == EDIT_U)) && (state_d != state_q);

      if (enter_edit || inc_evt) begin
         blink_cnt_d = BLINK_LD;
         phase_d     = 1'b0;
      end else if (in_edit) begin
         if (blink_cnt_q == '0) begin
            blink_cnt_d = BLINK_LD;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q - 1'b1;
         end
      end else begin
         blink_cnt_d = BLINK_LD;
         phase_d     = 1'b0;
      end

      if (enter_edit || inc_evt || bus.mode || !in_edit) tmo_cnt_d = TMO_LD;
      else if (tmo_cnt_q != '0)                           tmo_cnt_d = tmo_cnt_q - 1'b1;
   end

   assign bus.set_t   = (state_q == COMMIT_T);
   assign bus.set_u   = (state_q == COMMIT_U);
   assign bus.new_val = (state_q == COMMIT_T) ? sh_t_q :
                        (state_q == COMMIT_U) ? sh_u_q : 4'd0;
   assign bus.run_en  = (state_q == IDLE);
   assign bus.disp_t  = (state_q == IDLE) ? bus.cur_t : sh_t_q;
   assign bus.disp_u  = (state_q == IDLE) ? bus.cur_u : sh_u_q;
   assign bus.blank_t = (state_q == EDIT_T) & phase_q;
   assign bus.blank_u = (state_q == EDIT_U) & phase_q;

endmodule

// File: tb/tb_sec_set_ctrl.sv
// Bench for sec_set_ctrl: directed scenarios then random button traffic against a
// behavioural model; commit strobes are checked by a scoreboard monitor.
module tb_sec_set_ctrl;
   localparam int BLINK_HALF = 16;
   localparam int RPT_DELAY  = 8;
   localparam int RPT_PERIOD = 4;
   localparam int TIMEOUT    = 64;

   typedef enum int {M_IDLE, M_T, M_U, M_CT, M_CU} mst_e;
   typedef struct packed {
      logic       is_u;
      logic [3:0] val;
   } strobe_t;

   logic clk;
   logic resetn;
   int   checks   = 0;
   int   failures = 0;

   sec_set_ctrl_if bus ();

   sec_set_ctrl #(
      .BLINK_HALF (BLINK_HALF),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: session state, shadows, cycles held since the arming edge (-1 = not armed),
   // cycles since the last blink restart, consecutive inactive edges
   mst_e    ms;
   int      sh_t, sh_u;
   bit      up_prev;
   int      hold_k;
   int      age;
   int      quiet;
   strobe_t exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ms = M_IDLE; sh_t = 0; sh_u = 0; up_prev = 0; hold_k = -1; age = 0; quiet = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input bit m, input bit u, input int ct, input int cu);
      bit      edit, rise, fire, inc;
      int      k;
      strobe_t s;
      edit = (ms == M_T) || (ms == M_U);
      rise = u && !up_prev;
      if (!u || !edit)     k = -1;
      else if (rise)       k = 0;
      else if (hold_k >= 0) k = hold_k + 1;
      else                 k = -1;
      fire = (k == 0) || (k >= RPT_DELAY && ((k - RPT_DELAY) % RPT_PERIOD) == 0);
      inc  = fire && !m;
      hold_k  = k;
      up_prev = u;
      case (ms)
         M_IDLE: if (m) begin
            ms = M_T; sh_t = (ct > 5) ? 0 : ct; sh_u = (cu > 9) ? 0 : cu; age = 0; quiet = 0;
         end
         M_T, M_U: begin
            if (m) begin
               if (ms == M_T) ms = M_U;
               else begin
                  ms = M_CT;
                  s.is_u = 1'b0; s.val = 4'(sh_t); exp_q.push_back(s);
                  s.is_u = 1'b1; s.val = 4'(sh_u); exp_q.push_back(s);
               end
               age = 0; quiet = 0;
            end else if (inc) begin
               if (ms == M_T) sh_t = (sh_t + 1) % 6;
               else           sh_u = (sh_u + 1) % 10;
               age = 0; quiet = 0;
            end else begin
               age++; quiet++;
               if (quiet == TIMEOUT) ms = M_IDLE;
            end
         end
         M_CT: ms = M_CU;
         default: ms = M_IDLE;
      endcase
   endtask

   task automatic check_outputs();
      bit off;
      off = ((age / BLINK_HALF) % 2) == 1;
      chk("run_en",  int'(bus.run_en),  int'(ms == M_IDLE));
      chk("set_t",   int'(bus.set_t),   int'(ms == M_CT));
      chk("set_u",   int'(bus.set_u),   int'(ms == M_CU));
      if (ms != M_CT && ms != M_CU) chk("new_val_idle", int'(bus.new_val), 0);
      chk("disp_t",  int'(bus.disp_t),  (ms == M_IDLE) ? int'(bus.cur_t) : sh_t);
      chk("disp_u",  int'(bus.disp_u),  (ms == M_IDLE) ? int'(bus.cur_u) : sh_u);
      chk("blank_t", int'(bus.blank_t), int'(ms == M_T && off));
      chk("blank_u", int'(bus.blank_u), int'(ms == M_U && off));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_run_en",  int'(bus.run_en),  1);
      chk("rst_set_t",   int'(bus.set_t),   0);
      chk("rst_set_u",   int'(bus.set_u),   0);
      chk("rst_new_val", int'(bus.new_val), 0);
      chk("rst_disp_t",  int'(bus.disp_t),  int'(bus.cur_t));
      chk("rst_disp_u",  int'(bus.disp_u),  int'(bus.cur_u));
      chk("rst_blank_t", int'(bus.blank_t), 0);
      chk("rst_blank_u", int'(bus.blank_u), 0);
   endtask

   task automatic run_cycle(input bit m, input bit u);
      bus.mode = m;
      bus.up   = u;
      @(posedge clk);
      model_step(m, u, int'(bus.cur_t), int'(bus.cur_u));
      @(negedge clk);
      check_outputs();
   endtask

   task automatic pulse_up(input int n);
      for (int i = 0; i < n; i++) begin
         run_cycle(1'b0, 1'b1);
         run_cycle(1'b0, 1'b0);
      end
   endtask

   // scoreboard monitor for the commit strobes
   always @(negedge clk) begin
      if (resetn) begin
         if (bus.set_t && bus.set_u) begin
            checks++; failures++;
            $display("FAIL strobe_overlap: set_t=1 set_u=1 required never both");
         end else if (bus.set_t || bus.set_u) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL strobe_unexpected: set_t=%0d set_u=%0d required no strobe", bus.set_t, bus.set_u);
            end else begin
               strobe_t e;
               e = exp_q.pop_front();
               chk("strobe_is_u", int'(bus.set_u),   int'(e.is_u));
               chk("strobe_val",  int'(bus.new_val), int'(e.val));
            end
         end
      end
   end

   initial begin
      int  hold;
      bit  u;
      resetn   = 1'b0;
      bus.mode = 1'b0;
      bus.up   = 1'b0;
      bus.cur_t = 4'd3;
      bus.cur_u = 4'd7;
      model_reset();
      #1;
      chk_reset_outputs();
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // full edit: tens 4->5->0, units 8->9->0->1, then commit
      bus.cur_t = 4'd4; bus.cur_u = 4'd8;
      run_cycle(1'b1, 1'b0);
      pulse_up(2);
      chk("dir_sh_t_wrap", int'(bus.disp_t), 0);
      run_cycle(1'b1, 1'b0);
      pulse_up(3);
      chk("dir_sh_u_wrap", int'(bus.disp_u), 1);
      run_cycle(1'b1, 1'b0);
      chk("dir_commit_set_t", int'(bus.set_t), 1);
      chk("dir_commit_val_t", int'(bus.new_val), 0);
      run_cycle(1'b0, 1'b0);
      chk("dir_commit_set_u", int'(bus.set_u), 1);
      chk("dir_commit_val_u", int'(bus.new_val), 1);
      run_cycle(1'b0, 1'b0);
      chk("dir_commit_run_en", int'(bus.run_en), 1);

      // up held 20 cycles in EDIT_U: increments at k=0,8,12,16
      bus.cur_t = 4'd2; bus.cur_u = 4'd0;
      run_cycle(1'b1, 1'b0);
      run_cycle(1'b1, 1'b0);
      repeat (20) run_cycle(1'b0, 1'b1);
      chk("dir_auto_repeat", int'(bus.disp_u), 4);
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b1, 1'b0);
      repeat (3) run_cycle(1'b0, 1'b0);

      // up held across entry: no increment until released and pressed again
      bus.cur_t = 4'd2; bus.cur_u = 4'd5;
      repeat (3) run_cycle(1'b0, 1'b1);
      run_cycle(1'b1, 1'b1);
      repeat (15) run_cycle(1'b0, 1'b1);
      chk("dir_held_entry", int'(bus.disp_t), 2);
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b0, 1'b1);
      run_cycle(1'b0, 1'b0);
      chk("dir_repress", int'(bus.disp_t), 3);

      // timeout: abort on the 64th inactive edge after entering EDIT_U
      run_cycle(1'b1, 1'b0);
      repeat (TIMEOUT - 1) run_cycle(1'b0, 1'b0);
      chk("dir_tmo_before", int'(bus.run_en), 0);
      run_cycle(1'b0, 1'b0);
      chk("dir_tmo_abort", int'(bus.run_en), 1);

      // tens clamp, and mode beating an up edge in the same cycle
      bus.cur_t = 4'd9; bus.cur_u = 4'd3;
      run_cycle(1'b1, 1'b0);
      chk("dir_clamp_t", int'(bus.disp_t), 0);
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b1, 1'b1);
      chk("dir_mode_wins_t", int'(bus.disp_t), 0);
      chk("dir_mode_wins_blank", int'(bus.blank_u), 0);
      run_cycle(1'b0, 1'b0);
      pulse_up(4);
      chk("dir_sh_u_7", int'(bus.disp_u), 7);

      // asynchronous reset in the middle of EDIT_U
      resetn = 1'b0;
      #1;
      chk_reset_outputs();
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      bus.cur_t = 4'd1; bus.cur_u = 4'd2;
      run_cycle(1'b1, 1'b0);
      chk("dir_post_rst_t", int'(bus.disp_t), 1);
      chk("dir_post_rst_u", int'(bus.disp_u), 2);

      // random traffic
      hold = 0;
      u    = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            u    = ~u;
            hold = $urandom_range(1, 24);
         end
         hold--;
         if ($urandom_range(0, 7) == 0) begin
            bus.cur_t = 4'($urandom_range(0, 15));
            bus.cur_u = 4'($urandom_range(0, 15));
         end
         if (i % 800 == 400) repeat (TIMEOUT + 6) run_cycle(1'b0, 1'b0);
         run_cycle($urandom_range(0, 11) == 0, u);
      end
      repeat (4) run_cycle(1'b0, 1'b0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
